// File: rtl/bidir_xcvr_ctrl_pkg.sv
// Shared types and constants for the bidirectional transceiver controller.
// Holds the FSM state encoding and the direction constants.
package bidir_xcvr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_A2B  = 2'd1,
        ST_B2A  = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam logic DIR_B2A = 1'b0;
    localparam logic DIR_A2B = 1'b1;

    function automatic state_t dir_state(input logic dir);
        return (dir == DIR_A2B) ? ST_A2B : ST_B2A;
    endfunction

endpackage

// File: rtl/bidir_xcvr_ctrl_if.sv
// Control and status bundle of the transceiver; data ports stay as plain inout nets.
interface bidir_xcvr_ctrl_if;

    logic en;
    logic dir_req;
    logic a_oe;
    logic b_oe;
    logic dir_ack;
    logic busy;

    modport master (
        output en, dir_req,
        input  a_oe, b_oe, dir_ack, busy
    );

    modport slave (
        input  en, dir_req,
        output a_oe, b_oe, dir_ack, busy
    );

endinterface

// File: rtl/bidir_xcvr_ctrl_turn_timer.sv
// Turnaround down-counter: load, decrement while nonzero, zero flag.
module bidir_turn_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bidir_xcvr_ctrl.sv
// Registered bidirectional transceiver with turnaround dead cycles between
// releasing one port and driving the other.
module bidir_xcvr_ctrl
    import bidir_xcvr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bidir_xcvr_ctrl_if.slave     bus,
    inout  wire  [WIDTH-1:0]     a_io,
    inout  wire  [WIDTH-1:0]     b_io
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

    state_t             r_state;
    state_t             w_nxt;
    logic [WIDTH-1:0]   r_a_out_q;
    logic [WIDTH-1:0]   r_b_out_q;
    logic               w_load;
    logic               w_dec;
    logic               w_zero;
    logic               w_a_oe;
    logic               w_b_oe;

    bidir_turn_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (TURN_LOAD),
        .o_zero     (w_zero)
    );

    // The next state is needed both for the state register and for the data
    // capture enables, so it is decoded once here.
    always_comb begin
        w_nxt  = r_state;
        w_load = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.en) w_nxt = dir_state(bus.dir_req);
            end
            ST_A2B: begin
                if (!bus.en || (bus.dir_req != DIR_A2B)) begin
                    w_nxt  = ST_TURN;
                    w_load = 1'b1;
                end
            end
            ST_B2A: begin
                if (!bus.en || (bus.dir_req != DIR_B2A)) begin
                    w_nxt  = ST_TURN;
                    w_load = 1'b1;
                end
            end
            ST_TURN: begin
                if (w_zero) w_nxt = bus.en ? dir_state(bus.dir_req) : ST_IDLE;
            end
        endcase
    end

    assign w_dec = (r_state == ST_TURN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a_out_q <= '0;
            r_b_out_q <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt == ST_A2B) r_b_out_q <= a_io;
            if (w_nxt == ST_B2A) r_a_out_q <= b_io;
        end
    end

    assign w_a_oe      = (r_state == ST_B2A);
    assign w_b_oe      = (r_state == ST_A2B);
    assign bus.a_oe    = w_a_oe;
    assign bus.b_oe    = w_b_oe;
    assign bus.dir_ack = w_b_oe;
    assign bus.busy    = (r_state == ST_TURN);

    assign a_io = w_a_oe ? r_a_out_q : 'z;
    assign b_io = w_b_oe ? r_b_out_q : 'z;

endmodule

// File: tb/tb_bidir_xcvr_ctrl.sv
// Scoreboard bench for bidir_xcvr_ctrl: expectations queued per driven cycle, checked after the edge.
module tb_bidir_xcvr_ctrl;
    import bidir_xcvr_ctrl_pkg::*;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned TURN_CYC = 2;
    localparam int unsigned CNT_W    = 4;

    typedef struct {
        logic             a_oe;
        logic             b_oe;
        logic             busy;
        logic             dir_ack;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
    } exp_t;

    logic             clk = 1'b0;
    logic             tb_rst;
    logic [WIDTH-1:0] tb_a;
    logic [WIDTH-1:0] tb_b;
    wire  [WIDTH-1:0] a_io;
    wire  [WIDTH-1:0] b_io;

    bidir_xcvr_ctrl_if bus ();

    bidir_xcvr_ctrl #(
        .WIDTH    (WIDTH),
        .TURN_CYC (TURN_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (tb_rst),
        .bus  (bus),
        .a_io (a_io),
        .b_io (b_io)
    );

    // Bench drivers release each port whenever the DUT enables its own driver.
    assign a_io = bus.a_oe ? 'z : tb_a;
    assign b_io = bus.b_oe ? 'z : tb_b;

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb[$];

    // Reference model state
    int               m_state;   // 0 idle, 1 a2b, 2 b2a, 3 turn
    int               m_cnt;
    logic [WIDTH-1:0] m_aq;
    logic [WIDTH-1:0] m_bq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic d,
                              input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int   ns;
        exp_t x;
        if (r) begin
            ns    = 0;
            m_cnt = 0;
            m_aq  = '0;
            m_bq  = '0;
        end else begin
            ns = m_state;
            if (m_state == 0) begin
                if (e) ns = d ? 1 : 2;
            end else if (m_state == 1) begin
                if (!e || !d) begin ns = 3; m_cnt = TURN_CYC - 1; end
            end else if (m_state == 2) begin
                if (!e || d) begin ns = 3; m_cnt = TURN_CYC - 1; end
            end else begin
                if (m_cnt != 0) m_cnt = m_cnt - 1;
                else ns = !e ? 0 : (d ? 1 : 2);
            end
            if (ns == 1) m_bq = av;
            if (ns == 2) m_aq = bv;
        end
        m_state   = ns;
        x.a_oe    = (ns == 2);
        x.b_oe    = (ns == 1);
        x.busy    = (ns == 3);
        x.dir_ack = (ns == 1);
        x.a_q     = m_aq;
        x.b_q     = m_bq;
        sb.push_back(x);
    endtask

    task automatic step(input logic r, input logic e, input logic d,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        exp_t x;
        @(negedge clk);
        tb_rst      = r;
        bus.en      = e;
        bus.dir_req = d;
        tb_a        = av;
        tb_b        = bv;
        model_step(r, e, d, av, bv);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            check_eq("a_oe",    32'(bus.a_oe),    32'(x.a_oe));
            check_eq("b_oe",    32'(bus.b_oe),    32'(x.b_oe));
            check_eq("busy",    32'(bus.busy),    32'(x.busy));
            check_eq("dir_ack", 32'(bus.dir_ack), 32'(x.dir_ack));
            check_eq("contend", 32'(bus.a_oe & bus.b_oe), 32'd0);
            if (x.b_oe) check_eq("b_io", 32'(b_io), 32'(x.b_q));
            if (x.a_oe) check_eq("a_io", 32'(a_io), 32'(x.a_q));
        end
    endtask

    initial begin
        m_state     = 0;
        m_cnt       = 0;
        m_aq        = '0;
        m_bq        = '0;
        tb_rst      = 1'b1;
        bus.en      = 1'b0;
        bus.dir_req = 1'b0;
        tb_a        = '0;
        tb_b        = '0;

        // Reset for two cycles
        step(1, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00);
        check_eq("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

        // A->B with data following a_io each cycle
        step(0, 1, 1, 8'hA5, 8'h00);
        step(0, 1, 1, 8'h3C, 8'h00);
        step(0, 1, 1, 8'h3C, 8'h00);

        // Drop dir_req: two TURN cycles then B->A carrying 5A
        step(0, 1, 0, 8'h00, 8'h5A);
        step(0, 1, 0, 8'h00, 8'h5A);
        step(0, 1, 0, 8'h00, 8'h5A);
        step(0, 1, 0, 8'h00, 8'h77);

        // Leave B2A, flip request during TURN; still two TURN cycles, ends in A2B
        step(0, 1, 1, 8'h11, 8'h00);
        step(0, 1, 0, 8'h22, 8'h00);
        step(0, 1, 1, 8'h33, 8'h00);
        check_eq("toggle_ack", 32'(bus.dir_ack), 32'd1);

        // Back to B2A, then disable: TURN twice, IDLE, then direct re-entry to B2A
        step(0, 1, 0, 8'h00, 8'h44);
        step(0, 1, 0, 8'h00, 8'h44);
        step(0, 1, 0, 8'h00, 8'h45);
        step(0, 0, 0, 8'h00, 8'h46);
        step(0, 0, 0, 8'h00, 8'h46);
        step(0, 0, 0, 8'h00, 8'h46);
        step(0, 0, 0, 8'h00, 8'h46);
        step(0, 1, 0, 8'h00, 8'h9C);

        // Into A2B carrying FF, then reset mid-transfer
        step(0, 1, 1, 8'h00, 8'h00);
        step(0, 1, 1, 8'h00, 8'h00);
        step(0, 1, 1, 8'h00, 8'h00);
        step(0, 1, 1, 8'hFF, 8'h00);
        step(1, 1, 1, 8'hFF, 8'h00);
        check_eq("rst_mid_state", 32'(dut.r_state),   32'(ST_IDLE));
        check_eq("rst_mid_aq",    32'(dut.r_a_out_q), 32'd0);
        check_eq("rst_mid_bq",    32'(dut.r_b_out_q), 32'd0);

        // Random traffic with sticky request lines
        for (int i = 0; i < 400; i++) begin
            logic r, e, d;
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0;
            d = ($urandom_range(0, 5) == 0) ? ~bus.dir_req : bus.dir_req;
            step(r, e, d, 8'($urandom), 8'($urandom));
        end

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
